// File: rtl/span_fragment_emitter_pkg.sv
// Shared definitions for the span emitter and the z-buffer consumer:
// fragment word layout, default screen size and emitter state encoding.
package span_fragment_emitter_pkg;

   localparam int FRAG_W = 256;

   // Fragment word field positions (inclusive bit ranges)
   localparam int X_HI = 255;
   localparam int X_LO = 240;
   localparam int Y_HI = 239;
   localparam int Y_LO = 224;
   localparam int Z_HI = 223;
   localparam int Z_LO = 208;
   localparam int R_HI = 63;
   localparam int R_LO = 48;
   localparam int G_HI = 47;
   localparam int G_LO = 32;
   localparam int B_HI = 31;
   localparam int B_LO = 16;

   localparam int SCREEN_W = 640;
   localparam int SCREEN_H = 480;

   localparam logic [15:0] Z_MAX = 16'hFFFF;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_EMIT = 1'b1
   } emit_state_e;

   // Colour channels are zero-extended to 16 bits inside the word.
   function automatic logic [FRAG_W-1:0] pack_fragment(
      input logic [15:0] x,
      input logic [15:0] y,
      input logic [15:0] z,
      input logic [23:0] rgb
   );
      logic [FRAG_W-1:0] w;
      w              = '0;
      w[X_HI:X_LO]   = x;
      w[Y_HI:Y_LO]   = y;
      w[Z_HI:Z_LO]   = z;
      w[R_HI:R_LO]   = {8'h00, rgb[23:16]};
      w[G_HI:G_LO]   = {8'h00, rgb[15:8]};
      w[B_HI:B_LO]   = {8'h00, rgb[7:0]};
      return w;
   endfunction

endpackage

// File: rtl/span_fragment_emitter_depth_step_sat.sv
// Saturating depth step: z + dz with unsigned z and signed dz, clamped to the
// 16-bit unsigned depth range.
module depth_step_sat
   import span_fragment_emitter_pkg::*;
(
   input  logic [15:0] z_i,
   input  logic [15:0] dz_i,
   output logic [15:0] z_o
);

   logic signed [17:0] sum;

   always_comb begin
      sum = $signed({2'b00, z_i}) + $signed({{2{dz_i[15]}}, dz_i});
      if (sum < 18'sd0) begin
         z_o = 16'h0000;
      end else if (sum > 18'sd65535) begin
         z_o = Z_MAX;
      end else begin
         z_o = sum[15:0];
      end
   end

endmodule

// File: rtl/span_fragment_emitter.sv
// Walks one horizontal span per command and pushes one clipped, depth-stepped
// fragment per cycle into the z-buffer fragment queue.
module span_fragment_emitter #(
   parameter logic [15:0] QUEUE_DEPTH = 16'd1024,
   parameter int          SCREEN_W    = span_fragment_emitter_pkg::SCREEN_W,
   parameter int          SCREEN_H    = span_fragment_emitter_pkg::SCREEN_H
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         span_valid,
   output logic         span_ready,
   input  logic [15:0]  span_y,
   input  logic [15:0]  span_x0,
   input  logic [15:0]  span_x1,
   input  logic [15:0]  span_z0,
   input  logic [15:0]  span_dz,
   input  logic [23:0]  span_rgb,
   output logic         q_adding,
   output logic [255:0] q_add_regs,
   input  logic [15:0]  q_size,
   input  logic         q_err,
   output logic         busy,
   output logic [15:0]  frag_count,
   output logic         err
);

   import span_fragment_emitter_pkg::*;

   // Two-entry margin: q_size lags our own push by one cycle.
   localparam logic signed [17:0] PUSH_LIMIT = $signed({2'b00, QUEUE_DEPTH}) - 18'sd2;

   emit_state_e         state_q, state_d;
   logic [15:0]         y_q, y_d;
   logic [15:0]         x1_q, x1_d;
   logic [15:0]         cur_x_q, cur_x_d;
   logic [15:0]         cur_z_q, cur_z_d;
   logic [15:0]         dz_q, dz_d;
   logic [23:0]         rgb_q, rgb_d;
   logic                q_adding_q, q_adding_d;
   logic [FRAG_W-1:0]   q_add_regs_q, q_add_regs_d;
   logic [15:0]         frag_count_q;
   logic                err_q;

   logic [15:0]         z_step;
   logic                span_y_ok;
   logic                span_x_ok;
   logic                x_on_screen;
   logic                queue_room;
   logic                last_x;
   logic                advance;

   depth_step_sat u_depth_step_sat (
      .z_i  (cur_z_q),
      .dz_i (dz_q),
      .z_o  (z_step)
   );

   assign span_y_ok   = (int'($signed(span_y)) >= 0) && (int'($signed(span_y)) < SCREEN_H);
   assign span_x_ok   = $signed(span_x0) <= $signed(span_x1);
   assign x_on_screen = (int'($signed(cur_x_q)) >= 0) && (int'($signed(cur_x_q)) < SCREEN_W);
   assign queue_room  = $signed({2'b00, q_size}) <= PUSH_LIMIT;
   assign last_x      = (cur_x_q == x1_q);

   always_comb begin
      state_d      = state_q;
      y_d          = y_q;
      x1_d         = x1_q;
      cur_x_d      = cur_x_q;
      cur_z_d      = cur_z_q;
      dz_d         = dz_q;
      rgb_d        = rgb_q;
      q_adding_d   = 1'b0;
      q_add_regs_d = '0;
      advance      = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (span_valid) begin
               y_d     = span_y;
               x1_d    = span_x1;
               cur_x_d = span_x0;
               cur_z_d = span_z0;
               dz_d    = span_dz;
               rgb_d   = span_rgb;
               // Empty or off-screen spans are absorbed without leaving IDLE.
               if (span_x_ok && span_y_ok) begin
                  state_d = ST_EMIT;
               end
            end
         end

         ST_EMIT: begin
            if (!x_on_screen) begin
               advance = 1'b1;
            end else if (queue_room) begin
               advance      = 1'b1;
               q_adding_d   = 1'b1;
               q_add_regs_d = pack_fragment(cur_x_q, y_q, cur_z_q, rgb_q);
            end

            if (advance) begin
               cur_x_d = cur_x_q + 16'd1;
               cur_z_d = z_step;
               if (last_x) begin
                  state_d = ST_IDLE;
               end
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         y_q          <= '0;
         x1_q         <= '0;
         cur_x_q      <= '0;
         cur_z_q      <= '0;
         dz_q         <= '0;
         rgb_q        <= '0;
         q_adding_q   <= 1'b0;
         q_add_regs_q <= '0;
         frag_count_q <= '0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         y_q          <= y_d;
         x1_q         <= x1_d;
         cur_x_q      <= cur_x_d;
         cur_z_q      <= cur_z_d;
         dz_q         <= dz_d;
         rgb_q        <= rgb_d;
         q_adding_q   <= q_adding_d;
         q_add_regs_q <= q_add_regs_d;
         if (q_adding_q) begin
            frag_count_q <= frag_count_q + 16'd1;
         end
         if (q_err) begin
            err_q <= 1'b1;
         end
      end
   end

   assign span_ready = (state_q == ST_IDLE);
   assign busy       = (state_q == ST_EMIT);
   assign q_adding   = q_adding_q;
   assign q_add_regs = q_add_regs_q;
   assign frag_count = frag_count_q;
   assign err        = err_q;

endmodule

// File: tb/tb_span_fragment_emitter.sv
// Scoreboard bench: a span-level model queues expected fragment words, and an
// independent monitor pops and compares them whenever the emitter pushes.
module tb_span_fragment_emitter;

   localparam logic [15:0] QD = 16'd1024;
   localparam int          W  = 640;
   localparam int          H  = 480;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         span_valid = 1'b0;
   logic         span_ready;
   logic [15:0]  span_y = '0;
   logic [15:0]  span_x0 = '0;
   logic [15:0]  span_x1 = '0;
   logic [15:0]  span_z0 = '0;
   logic [15:0]  span_dz = '0;
   logic [23:0]  span_rgb = '0;
   logic         q_adding;
   logic [255:0] q_add_regs;
   logic [15:0]  q_size = '0;
   logic         q_err = 1'b0;
   logic         busy;
   logic [15:0]  frag_count;
   logic         err;

   span_fragment_emitter #(
      .QUEUE_DEPTH (QD),
      .SCREEN_W    (W),
      .SCREEN_H    (H)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .span_valid (span_valid),
      .span_ready (span_ready),
      .span_y     (span_y),
      .span_x0    (span_x0),
      .span_x1    (span_x1),
      .span_z0    (span_z0),
      .span_dz    (span_dz),
      .span_rgb   (span_rgb),
      .q_adding   (q_adding),
      .q_add_regs (q_add_regs),
      .q_size     (q_size),
      .q_err      (q_err),
      .busy       (busy),
      .frag_count (frag_count),
      .err        (err)
   );

   always #5 clk = ~clk;

   logic [255:0] exp_q[$];
   int           n_checks = 0;
   int           n_fail = 0;
   int           exp_total = 0;
   bit           rand_qs = 1'b0;
   logic [15:0]  qs_at_edge = '0;

   always @(posedge clk) qs_at_edge <= q_size;

   task automatic chk(input string name, input longint act, input longint exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic logic [255:0] make_word(input int x, input int y, input int z,
                                              input logic [23:0] rgb);
      logic [255:0] w;
      w = '0;
      w[255:240] = 16'(x);
      w[239:224] = 16'(y);
      w[223:208] = 16'(z);
      w[63:48]   = {8'h00, rgb[23:16]};
      w[47:32]   = {8'h00, rgb[15:8]};
      w[31:16]   = {8'h00, rgb[7:0]};
      return w;
   endfunction

   // Span-level reference: every on-screen x gets a fragment, depth walks per pixel.
   function automatic void model_span(input int y, input int x0, input int x1, input int z0,
                                      input int dz, input logic [23:0] rgb);
      int z;
      if (x0 > x1 || y < 0 || y >= H) return;
      z = z0;
      for (int x = x0; x <= x1; x++) begin
         if (x >= 0 && x < W) begin
            exp_q.push_back(make_word(x, y, z, rgb));
            exp_total++;
         end
         z = z + dz;
         if (z < 0) z = 0;
         if (z > 65535) z = 65535;
      end
   endfunction

   // Monitor: pops one expectation per push.
   initial begin
      logic [255:0] w;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            chk("ready_xor_busy", span_ready, !busy);
            if (q_adding) begin
               n_checks++;
               if (exp_q.size() == 0) begin
                  n_fail++;
                  $display("FAIL unexpected_push: got x=%0d z=%0h expected no push",
                           $signed(q_add_regs[255:240]), q_add_regs[223:208]);
               end else begin
                  w = exp_q.pop_front();
                  if (q_add_regs !== w) begin
                     n_fail++;
                     $display("FAIL fragment: got x=%0d y=%0d z=%0h rgbw=%0h expected x=%0d y=%0d z=%0h rgbw=%0h",
                              $signed(q_add_regs[255:240]), $signed(q_add_regs[239:224]),
                              q_add_regs[223:208], q_add_regs[63:16],
                              $signed(w[255:240]), $signed(w[239:224]), w[223:208], w[63:16]);
                  end
               end
               chk("push_with_room", (qs_at_edge <= QD - 16'd2) ? 1 : 0, 1);
            end
         end
      end
   end

   // Background queue occupancy for the randomized phase.
   initial begin
      int r;
      forever begin
         @(negedge clk);
         if (rand_qs) begin
            r = int'($urandom_range(0, 9));
            if (r < 6)       q_size = 16'd0;
            else if (r == 6) q_size = QD - 16'd2;
            else if (r == 7) q_size = QD - 16'd1;
            else if (r == 8) q_size = QD;
            else             q_size = 16'd3000;
         end
      end
   end

   // Returns just after the first falling edge following acceptance.
   task automatic send_span(input int y, input int x0, input int x1, input int z0,
                            input int dz, input logic [23:0] rgb);
      int g;
      g = 0;
      @(negedge clk);
      while (!span_ready && g < 3000) begin
         @(negedge clk);
         g++;
      end
      chk("span_ready_wait", span_ready, 1);
      model_span(y, x0, x1, z0, dz, rgb);
      span_y     = 16'(y);
      span_x0    = 16'(x0);
      span_x1    = 16'(x1);
      span_z0    = 16'(z0);
      span_dz    = 16'(dz);
      span_rgb   = rgb;
      span_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      span_valid = 1'b0;
   endtask

   // Counts falling edges after acceptance until the first push and until ready.
   task automatic measure(output int first_n, output int ready_n);
      int n;
      n = 1;
      first_n = 0;
      ready_n = 0;
      while (n < 300) begin
         if (q_adding && first_n == 0) first_n = n;
         if (span_ready) begin
            ready_n = n;
            break;
         end
         @(negedge clk);
         n++;
      end
   endtask

   task automatic wait_idle();
      int g;
      g = 0;
      while (!span_ready && g < 3000) begin
         @(negedge clk);
         g++;
      end
      @(negedge clk);
      chk("drain_leftover", exp_q.size(), 0);
      chk("frag_count", frag_count, exp_total & 16'hFFFF);
   endtask

   task automatic run_span(input int y, input int x0, input int x1, input int z0,
                           input int dz, input logic [23:0] rgb, input bit timing);
      int f, r, ef, er, xs;
      send_span(y, x0, x1, z0, dz, rgb);
      measure(f, r);
      if (timing) begin
         xs = (x0 < 0) ? 0 : x0;
         if (x0 > x1 || y < 0 || y >= H) begin
            ef = 0;
            er = 1;
         end else begin
            ef = (xs <= x1 && xs < W) ? (xs - x0 + 2) : 0;
            er = x1 - x0 + 2;
         end
         chk("first_push_cycle", f, ef);
         chk("ready_return_cycle", r, er);
      end
      wait_idle();
   endtask

   initial begin
      #5_000_000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      // Reset values
      repeat (3) @(negedge clk);
      chk("rst_span_ready", span_ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_q_adding", q_adding, 0);
      chk("rst_q_add_regs_zero", (q_add_regs == '0) ? 1 : 0, 1);
      chk("rst_frag_count", frag_count, 0);
      chk("rst_err", err, 0);
      rst_n = 1'b1;

      // Basic span, rgb fields, four pushes
      run_span(10, 5, 8, 100, 10, 24'hFF8000, 1'b1);
      // Left clipping
      run_span(0, -2, 1, 0, 1, 24'h123456, 1'b1);

      // Backpressure hold mid-span
      send_span(20, 0, 9, 50, 3, 24'hA1B2C3);
      repeat (2) @(negedge clk);
      q_size = QD - 16'd1;
      repeat (5) @(negedge clk);
      q_size = 16'd0;
      wait_idle();

      // Exactly at the margin: no stall
      q_size = QD - 16'd2;
      run_span(30, 600, 606, 7, 1, 24'h010203, 1'b1);
      q_size = 16'd0;

      // Depth saturation both ways
      run_span(1, 0, 2, 16'hFFF0, 16, 24'h00FF00, 1'b1);
      run_span(2, 0, 1, 5, -10, 24'h0000FF, 1'b1);

      // Degenerate and clipped spans
      run_span(3, 7, 3, 1, 1, 24'h111111, 1'b1);
      run_span(480, 0, 3, 1, 1, 24'h222222, 1'b1);
      run_span(-1, 0, 3, 1, 1, 24'h333333, 1'b1);
      run_span(479, 636, 645, 9, 2, 24'h444444, 1'b1);
      run_span(0, 0, 0, 42, 1, 24'h555555, 1'b1);

      // Sticky error
      @(negedge clk);
      q_err = 1'b1;
      @(negedge clk);
      q_err = 1'b0;
      @(negedge clk);
      chk("err_set", err, 1);
      run_span(4, 10, 12, 0, 100, 24'h666666, 1'b1);
      chk("err_sticky", err, 1);

      // Mid-span reset
      send_span(5, 0, 40, 0, 1, 24'h777777);
      repeat (4) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_q_adding", q_adding, 0);
      chk("midrst_frag_count", frag_count, 0);
      chk("midrst_span_ready", span_ready, 1);
      chk("midrst_busy", busy, 0);
      chk("midrst_err", err, 0);
      chk("midrst_q_add_regs_zero", (q_add_regs == '0) ? 1 : 0, 1);
      exp_q.delete();
      exp_total = 0;
      @(negedge clk);
      rst_n = 1'b1;
      run_span(6, 100, 104, 1000, -3, 24'h89ABCD, 1'b1);

      // Randomized spans under random backpressure
      rand_qs = 1'b1;
      for (int i = 0; i < 30; i++) begin
         int ry, rx0, rx1, rz0, rdz;
         ry  = int'($urandom_range(0, 489)) - 5;
         rx0 = int'($urandom_range(0, 720)) - 40;
         rx1 = rx0 + int'($urandom_range(0, 44)) - 4;
         rz0 = int'($urandom_range(0, 65535));
         rdz = int'($urandom_range(0, 4000)) - 2000;
         run_span(ry, rx0, rx1, rz0, rdz, 24'($urandom), 1'b0);
      end
      rand_qs = 1'b0;
      @(negedge clk);
      q_size = 16'd0;
      chk("err_final", err, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/span_fragment_emitter.md
SPAN_FRAGMENT_EMITTER -- requirements
Module: span_fragment_emitter

Interface
REQ-001 Parameter QUEUE_DEPTH, default 16'd1024: capacity of the downstream z-buffer fragment queue.
REQ-002 Parameter SCREEN_W, default 640: fragments with x outside 0..SCREEN_W-1 are clipped.
REQ-003 Parameter SCREEN_H, default 480: spans with y outside 0..SCREEN_H-1 are clipped.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous and active-low.
REQ-006 span_valid  input  1  span command present.
REQ-007 span_ready  output  1  emitter can accept a span.
REQ-008 span_y  input  16  signed scanline y.
REQ-009 span_x0, span_x1  input  16 each  signed inclusive start and end x.
REQ-010 span_z0  input  16  unsigned depth at x0.
REQ-011 span_dz  input  16  signed depth increment per pixel.
REQ-012 span_rgb  input  24  {r,g,b}, 8 bits each.
REQ-013 q_adding  output  1  one-cycle push strobe to the fragment queue.
REQ-014 q_add_regs  output  256  fragment word; valid only while q_adding=1.
REQ-015 q_size  input  16  current queue occupancy.
REQ-016 q_err  input  1  queue overflow/underflow indication.
REQ-017 busy  output  1  a span is being walked.
REQ-018 frag_count  output  16  total fragments pushed since reset; wraps at 16'hFFFF.
REQ-019 err  output  1  sticky; set when q_err=1 is sampled.

Function
REQ-020 States are IDLE and EMIT; span_ready=1 only in IDLE, and busy=1 only in EMIT.
REQ-021 IDLE: a span is accepted on span_valid&span_ready. All span fields are registered. The next state is EMIT, with cur_x=x0 and cur_z=z0.
REQ-022 An accepted span with x0>x1 (signed compare), or with y outside 0..SCREEN_H-1, produces no fragments. The block stays in IDLE with span_ready=1 in the next cycle.
REQ-023 EMIT processes cur_x in one cycle when cur_x lies outside 0..SCREEN_W-1. The result is no push, then advance to the next x.
REQ-024 EMIT pushes an in-screen cur_x only when q_size <= QUEUE_DEPTH-2; this margin covers the one-cycle q_size update lag.
REQ-025 Otherwise an in-screen cur_x stalls: no push and no advance.
REQ-026 Push: q_adding=1 for exactly one cycle, with q_add_regs fields as follows:
  - [255:240]=cur_x
  - [239:224]=y
  - [223:208]=cur_z
  - [63:48]={8'h00,r}
  - [47:32]={8'h00,g}
  - [31:16]={8'h00,b}
  - all other bits 0
REQ-027 Pushes are registered outputs: a push decision in cycle N drives q_adding in cycle N+1. Throughput is at most one fragment per cycle.
REQ-028 Advance: cur_x<=cur_x+1 and cur_z<=sat(cur_z+dz). sat clamps to 0..16'hFFFF, computed at 17+ bit signed width.
REQ-029 After the fragment at cur_x==x1 is pushed or clipped, the next state is IDLE. span_ready=1 the following cycle; back-to-back spans have one IDLE cycle between them.
REQ-030 frag_count increments on every cycle with q_adding=1.
REQ-031 q_err=1 sets err; err is cleared only by reset and does not stop emission.

Reset
REQ-032 rst_n=0 asynchronously forces the following values, including mid-span; the partially emitted span is discarded:
  - state=IDLE, span_ready=1, busy=0
  - q_adding=0, q_add_regs=0
  - frag_count=0, err=0
  - all span registers 0
REQ-033 After rst_n deassertion, span_ready=1 and a span may be accepted on the first rising edge.

Structure
REQ-034 A shared package holds the following; the z-buffer consumer and this block both use these definitions:
  - fragment field bit positions: X_HI/LO, Y, Z, R, G, B
  - SCREEN_W, SCREEN_H
  - the state encoding
REQ-035 One sub-module, depth_step_sat, implements the saturating z increment combinationally; everything else is flat.

Verification
REQ-036 Span y=10, x0=5, x1=8, z0=100, dz=10, rgb=FF8000, q_size=0: four pushes, x=5..8, z=100,110,120,130, [63:48]=00FF, [47:32]=0080. frag_count=4; span_ready returns after the last push.
REQ-037 Span x0=-2, x1=1, y=0: fragments only at x=0 and x=1. Two cycles pass with no push before the first push.
REQ-038 q_size held at QUEUE_DEPTH-1 for 5 cycles mid-span, then 0: no pushes during the hold. Emission resumes with no lost or duplicated x.
REQ-039 Span z0=16'hFFF0, dz=16 for 3 pixels gives z=FFF0, FFFF, FFFF. Span z0=5, dz=-10 gives z=5, 0.
REQ-040 Degenerate spans and mid-span reset:
  - x0=7, x1=3: zero pushes.
  - y=480: zero pushes.
  - rst_n low mid-span: q_adding=0 immediately, frag_count=0; a new span after release emits correctly.
REQ-041 Pulse q_err for one cycle: err=1 and stays 1 until reset.
